// File: rtl/core_pkg.sv
// Shared core definitions: PC-source encodings, NOP instruction and opcodes.
// Imported by the fetch unit and the Controller.
package core_pkg;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JALR   = 2'b10,
    PC_SRC_RSVD   = 2'b11
  } pc_src_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_unit_if.sv
// Controller/datapath <-> fetch unit signal bundle.
// master = Controller/datapath side, slave = fetch unit.
interface fetch_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             PCWrite;
  logic             PCWriteCond;
  logic             Zero;
  logic [1:0]       PCSource;
  logic             lorD;
  logic             IRWrite;
  logic [XLEN-1:0]  MemRdData;
  logic [XLEN-1:0]  ALUResult;
  logic [XLEN-1:0]  ALUOut;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  old_pc;
  logic [XLEN-1:0]  mem_addr;
  logic [31:0]      instr;
  logic [XLEN-1:0]  mdr;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [6:0]       funct7;
  logic             misalign_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output PCWrite, PCWriteCond, Zero, PCSource, lorD, IRWrite,
           MemRdData, ALUResult, ALUOut,
    input  pc, old_pc, mem_addr, instr, mdr, opcode, rd, funct3,
           rs1, rs2, funct7, misalign_err, instr_count
  );

  modport slave (
    input  PCWrite, PCWriteCond, Zero, PCSource, lorD, IRWrite,
           MemRdData, ALUResult, ALUOut,
    output pc, old_pc, mem_addr, instr, mdr, opcode, rd, funct3,
           rs1, rs2, funct7, misalign_err, instr_count
  );
endinterface

// File: rtl/fetch_unit_en_reg.sv
// Parameterised-width register with load enable and async active-high reset.
module en_reg #(
  parameter int unsigned         W       = 32,
  parameter logic [W-1:0]        RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: PC, IR, old-PC and MDR registers, address mux,
// retired-fetch counter and sticky PC-misalignment flag.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  fetch_unit_if.slave bus
);
  pc_src_e          src;
  logic             pc_en;
  logic             pc_load;
  logic             mis_hit;
  logic [XLEN-1:0]  next_pc;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  old_pc_q;
  logic [XLEN-1:0]  mdr_q;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mis_q;

  assign src = pc_src_e'(bus.PCSource);

  // Reserved source suppresses the load entirely (no flag update either).
  always_comb begin
    next_pc = pc_q;
    case (src)
      PC_SRC_ALU:    next_pc = bus.ALUResult;
      PC_SRC_ALUOUT: next_pc = bus.ALUOut;
      PC_SRC_JALR:   next_pc = {bus.ALUResult[XLEN-1:1], 1'b0};
      default:       next_pc = pc_q;
    endcase
    pc_en   = bus.PCWrite | (bus.PCWriteCond & bus.Zero);
    pc_load = pc_en && (src != PC_SRC_RSVD);
    mis_hit = pc_load && (next_pc[1:0] != 2'b00);
    pc_d    = {next_pc[XLEN-1:2], 2'b00};
  end

  en_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(pc_load), .d(pc_d), .q(pc_q)
  );

  en_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_old_pc (
    .clk(clk), .reset(reset), .en(bus.IRWrite), .d(pc_q), .q(old_pc_q)
  );

  en_reg #(.W(32), .RST_VAL(NOP_INSTR)) u_ir (
    .clk(clk), .reset(reset), .en(bus.IRWrite), .d(bus.MemRdData[31:0]), .q(instr_q)
  );

  en_reg #(.W(XLEN), .RST_VAL('0)) u_mdr (
    .clk(clk), .reset(reset), .en(1'b1), .d(bus.MemRdData), .q(mdr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      if (bus.IRWrite) cnt_q <= cnt_q + CNT_W'(1);
      if (mis_hit)     mis_q <= 1'b1;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.old_pc       = old_pc_q;
  assign bus.mem_addr     = bus.lorD ? bus.ALUOut : pc_q;
  assign bus.instr        = instr_q;
  assign bus.mdr          = mdr_q;
  assign bus.opcode       = instr_q[6:0];
  assign bus.rd           = instr_q[11:7];
  assign bus.funct3       = instr_q[14:12];
  assign bus.rs1          = instr_q[19:15];
  assign bus.rs2          = instr_q[24:20];
  assign bus.funct7       = instr_q[31:25];
  assign bus.misalign_err = mis_q;
  assign bus.instr_count  = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expectations are queued as each step is
// driven and popped against the DUT once the step's result is visible.
module tb_fetch_unit;
  import core_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  fetch_unit_if #(.XLEN(32), .CNT_W(4)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_reset_state();
    push("rst_pc",     32'h0);
    push("rst_old_pc", 32'h0);
    push("rst_instr",  32'h0000_0013);
    push("rst_opcode", 32'h13);
    push("rst_mdr",    32'h0);
    push("rst_mis",    32'h0);
    push("rst_cnt",    32'h0);
  endtask

  task automatic chk_reset_state();
    chk(bus.pc);
    chk(bus.old_pc);
    chk(bus.instr);
    chk(32'(bus.opcode));
    chk(bus.mdr);
    chk(32'(bus.misalign_err));
    chk(32'(bus.instr_count));
  endtask

  initial begin
    reset           = 1'b1;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.Zero        = 1'b0;
    bus.PCSource    = 2'b00;
    bus.lorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemRdData   = 32'h0;
    bus.ALUResult   = 32'h0;
    bus.ALUOut      = 32'h0;

    // Reset before any clock edge
    push_reset_state();
    #2;
    chk_reset_state();
    #1 reset = 1'b0;

    // Fetch: PC+4 and IR load on the same edge
    bus.PCWrite   = 1'b1;
    bus.IRWrite   = 1'b1;
    bus.PCSource  = 2'b00;
    bus.ALUResult = 32'h4;
    bus.MemRdData = 32'h00B5_0533;
    push("f_pc", 32'h4); push("f_old_pc", 32'h0); push("f_opcode", 32'h33);
    push("f_rd", 32'd10); push("f_rs1", 32'd10); push("f_rs2", 32'd11);
    push("f_funct3", 32'd0); push("f_funct7", 32'd0); push("f_cnt", 32'd1);
    tick();
    chk(bus.pc); chk(bus.old_pc); chk(32'(bus.opcode));
    chk(32'(bus.rd)); chk(32'(bus.rs1)); chk(32'(bus.rs2));
    chk(32'(bus.funct3)); chk(32'(bus.funct7)); chk(32'(bus.instr_count));

    // Branch not taken
    bus.PCWrite     = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCWriteCond = 1'b1;
    bus.Zero        = 1'b0;
    bus.PCSource    = 2'b01;
    bus.ALUOut      = 32'h40;
    push("br_nt_pc", 32'h4);
    tick();
    chk(bus.pc);

    // Branch taken
    bus.Zero = 1'b1;
    push("br_t_pc", 32'h40);
    tick();
    chk(bus.pc);

    // Reserved source holds PC even with PCWrite
    bus.PCWriteCond = 1'b0;
    bus.Zero        = 1'b0;
    bus.PCWrite     = 1'b1;
    bus.PCSource    = 2'b11;
    bus.ALUResult   = 32'h80;
    bus.ALUOut      = 32'h84;
    push("rsvd_pc", 32'h40); push("rsvd_mis", 32'h0);
    tick();
    chk(bus.pc); chk(32'(bus.misalign_err));

    // JALR clears bit 0
    bus.PCSource  = 2'b10;
    bus.ALUResult = 32'h45;
    push("jalr_pc", 32'h44); push("jalr_mis", 32'h0);
    tick();
    chk(bus.pc); chk(32'(bus.misalign_err));

    // Misaligned target is word-aligned and flagged
    bus.PCSource  = 2'b00;
    bus.ALUResult = 32'h22;
    push("mis_pc", 32'h20); push("mis_flag", 32'h1);
    tick();
    chk(bus.pc); chk(32'(bus.misalign_err));

    // Flag stays set after an aligned load
    bus.ALUResult = 32'h24;
    push("mis2_pc", 32'h24); push("mis2_flag", 32'h1);
    tick();
    chk(bus.pc); chk(32'(bus.misalign_err));

    // Address mux is combinational
    bus.PCWrite = 1'b0;
    bus.lorD    = 1'b1;
    bus.ALUOut  = 32'h100;
    push("addr_aluout", 32'h100);
    #1 chk(bus.mem_addr);
    bus.lorD = 1'b0;
    push("addr_pc", 32'h24);
    #1 chk(bus.mem_addr);

    // MDR loads every edge; IR holds without IRWrite
    bus.MemRdData = 32'hDEAD_BEEF;
    push("mdr", 32'hDEAD_BEEF); push("ir_hold", 32'h00B5_0533); push("cnt_hold", 32'd1);
    tick();
    chk(bus.mdr); chk(bus.instr); chk(32'(bus.instr_count));

    // Second fetch: old_pc captures pre-increment PC
    bus.PCWrite   = 1'b1;
    bus.IRWrite   = 1'b1;
    bus.ALUResult = 32'h28;
    bus.MemRdData = {25'h0, OP_LOAD};
    push("f2_pc", 32'h28); push("f2_old_pc", 32'h24);
    push("f2_opcode", 32'(OP_LOAD)); push("f2_cnt", 32'd2);
    tick();
    chk(bus.pc); chk(bus.old_pc); chk(32'(bus.opcode)); chk(32'(bus.instr_count));

    // Counter wraps at 16 (4-bit)
    bus.PCWrite = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus.MemRdData = 32'h1000 + 32'(i);
      tick();
    end
    push("cnt_15", 32'd15);
    chk(32'(bus.instr_count));
    push("cnt_wrap", 32'd0);
    tick();
    chk(32'(bus.instr_count));

    // Mid-sequence async reset between edges
    push("pre_rst_cnt", 32'd2);
    tick();
    tick();
    chk(32'(bus.instr_count));
    #2 reset = 1'b1;
    push_reset_state();
    #1 chk_reset_state();
    #1 reset = 1'b0;
    bus.IRWrite = 1'b0;

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish before 20000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC stage of the multicycle core.
- Directly upstream of Controller: holds PC, instruction register (IR), old-PC and memory-data register (MDR); drives opcode and decoded instruction fields into Controller.
- Consumes Controller's PCWrite, PCWriteCond, PCSource, lorD, IRWrite, plus ALU Zero/results, to sequence the PC and select the memory address.
- Maintains a retired-fetch counter and a sticky PC-misalignment flag.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h00000000, PC value on reset
CNT_W, 32, width of instr_count

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
PCWrite  in  1  unconditional PC load
PCWriteCond  in  1  PC load qualified by Zero
Zero  in  1  ALU zero flag
PCSource  in  2  next-PC select
lorD  in  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  in  1  latch instruction from memory
MemRdData  in  XLEN  memory read data
ALUResult  in  XLEN  combinational ALU output
ALUOut  in  XLEN  registered ALU output
pc  out  XLEN  current PC
old_pc  out  XLEN  PC of the instruction currently in IR
mem_addr  out  XLEN  memory address
instr  out  32  instruction register
mdr  out  XLEN  memory data register
opcode  out  7  instr[6:0], feeds Controller
rd  out  5  instr[11:7]
funct3  out  3  instr[14:12]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
funct7  out  7  instr[31:25]
misalign_err  out  1  sticky misaligned-PC flag
instr_count  out  CNT_W  number of IRWrite pulses

Behaviour:
- Reset (async, active-high) clears state immediately, independent of clk, including mid-cycle:
  - pc = RESET_PC; old_pc = RESET_PC
  - instr = 32'h00000013 (NOP), so opcode = 7'b0010011
  - mdr = 0; misalign_err = 0; instr_count = 0
- pc_en = PCWrite | (PCWriteCond & Zero), evaluated at the rising edge.
- next_pc by PCSource:
  - 00: ALUResult (PC+4)
  - 01: ALUOut (branch target)
  - 10: {ALUResult[XLEN-1:1], 1'b0} (JALR target)
  - 11: reserved; pc holds even when pc_en = 1
- PC misalignment: if pc_en and next_pc[1:0] != 0:
  - pc loads {next_pc[XLEN-1:2], 2'b00}
  - misalign_err sets and stays set until reset
- IRWrite = 1 at an edge:
  - instr <= MemRdData
  - old_pc <= pc value before that edge
  - instr_count <= instr_count + 1, wrapping to 0 at 2^CNT_W
- Simultaneous PCWrite and IRWrite (Fetch state): all three updates occur on the same edge; old_pc captures the pre-increment PC.
- mdr <= MemRdData on every edge, unconditional; one-cycle latency.
- Combinational outputs:
  - mem_addr = lorD ? ALUOut : pc (zero latency)
  - opcode, rd, funct3, rs1, rs2, funct7 are slices of instr.
- PCWriteCond = 1 with Zero = 0: pc unchanged.
- Unknown or X inputs are not required to be handled.

Decomposition:
- Shared package core_pkg holds:
  - PCSource encodings: PC_SRC_ALU, PC_SRC_ALUOUT, PC_SRC_JALR, PC_SRC_RSVD
  - NOP_INSTR constant
  - opcode constants: OP_RTYPE 0110011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011
  - Controller uses the same package.
- One sub-module: en_reg, a parameterised-width register with enable, async active-high reset and a reset-value parameter. It is used for pc, old_pc, instr and mdr.

Test Plan:
- Reset asserted, no clock -> pc = 0, old_pc = 0, instr = 0x00000013, opcode = 0x13, instr_count = 0, misalign_err = 0.
- Fetch: PCWrite = 1, IRWrite = 1, PCSource = 00, ALUResult = 4, MemRdData = 0x00B50533, one edge -> pc = 4, old_pc = 0, opcode = 0110011, rd = 10, rs1 = 10, rs2 = 11, funct3 = 0, instr_count = 1.
- Branch: PCWriteCond = 1, Zero = 0, PCSource = 01, ALUOut = 0x40 -> pc stays 4. Then Zero = 1 -> pc = 0x40. Then PCSource = 11 with PCWrite = 1 -> pc stays 0x40.
- Misalign: PCWrite = 1, PCSource = 00, ALUResult = 0x22 -> pc = 0x20, misalign_err = 1. Then ALUResult = 0x24 -> pc = 0x24, misalign_err still 1.
- Address mux and MDR: lorD = 1, ALUOut = 0x100 -> mem_addr = 0x100 immediately; lorD = 0 -> mem_addr = pc. MemRdData = 0xDEADBEEF -> mdr = 0xDEADBEEF after one edge, with IRWrite = 0 and instr unchanged.
- Wrap/reset: CNT_W = 4, 16 IRWrite pulses -> instr_count = 0. Reset asserted between edges mid-sequence -> all outputs return to reset values before the next edge.
